// File: rtl/gcd_unit_param.sv
// gcd_unit_param: stream GCD engine, subtractive Euclid or binary Stein,
// with a one-entry result buffer so a new operand pair can start early.
module gcd_unit_param #(
  parameter int unsigned p_nbits = 16,
  parameter int unsigned p_algo  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   istream_val_i,
  output logic                   istream_rdy_o,
  input  logic [2*p_nbits-1:0]   istream_msg_i,
  output logic                   ostream_val_o,
  input  logic                   ostream_rdy_i,
  output logic [p_nbits-1:0]     ostream_msg_o
);

  localparam int unsigned KW = $clog2(p_nbits) + 1;
  localparam int unsigned HD = (p_nbits + 3) / 4;
  localparam int unsigned TW = 8 * (2 * HD + 1);

  typedef logic [p_nbits-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  word_t         a_q, a_d;
  word_t         b_q, b_d;
  word_t         res_q, res_d;
  word_t         buf_q, buf_d;
  logic [KW-1:0] k_q, k_d;
  logic          bv_q, bv_d;

  logic          st_done;
  word_t         st_res;
  word_t         st_a;
  word_t         st_b;
  logic [KW-1:0] st_k;
  logic          buf_free;

  generate
    if (p_algo == 0) begin : g_euclid
      // One subtractive Euclid step on the working pair.
      always_comb begin
        st_done = 1'b0;
        st_res  = '0;
        st_a    = a_q;
        st_b    = b_q;
        st_k    = k_q;
        if (a_q < b_q) begin
          st_a = b_q;
          st_b = a_q;
        end else if (b_q != '0) begin
          st_a = a_q - b_q;
        end else begin
          st_done = 1'b1;
          st_res  = a_q;
        end
      end
    end else begin : g_stein
      // One binary Stein step; K counts common factors of two.
      always_comb begin
        st_done = 1'b0;
        st_res  = '0;
        st_a    = a_q;
        st_b    = b_q;
        st_k    = k_q;
        if (a_q == '0) begin
          st_done = 1'b1;
          st_res  = b_q << k_q;
        end else if (b_q == '0) begin
          st_done = 1'b1;
          st_res  = a_q << k_q;
        end else if (!a_q[0] && !b_q[0]) begin
          st_a = a_q >> 1;
          st_b = b_q >> 1;
          st_k = k_q + KW'(1);
        end else if (!a_q[0]) begin
          st_a = a_q >> 1;
        end else if (!b_q[0]) begin
          st_b = b_q >> 1;
        end else if (a_q >= b_q) begin
          st_a = a_q - b_q;
        end else begin
          st_b = b_q - a_q;
        end
      end
    end
  endgenerate

  assign buf_free = !bv_q || ostream_rdy_i;

  // Next-state: operand load, stepping, and result hand-off to the buffer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    res_d   = res_q;
    buf_d   = buf_q;
    bv_d    = bv_q && !ostream_rdy_i;
    unique case (state_q)
      S_IDLE: begin
        if (istream_val_i) begin
          a_d     = istream_msg_i[2*p_nbits-1:p_nbits];
          b_d     = istream_msg_i[p_nbits-1:0];
          k_d     = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (st_done) begin
          if (buf_free) begin
            bv_d    = 1'b1;
            buf_d   = st_res;
            state_d = S_IDLE;
          end else begin
            res_d   = st_res;
            state_d = S_DONE;
          end
        end else begin
          a_d = st_a;
          b_d = st_b;
          k_d = st_k;
        end
      end
      S_DONE: begin
        if (buf_free) begin
          bv_d    = 1'b1;
          buf_d   = res_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      buf_q   <= '0;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      res_q   <= res_d;
      buf_q   <= buf_d;
      bv_q    <= bv_d;
    end
  end

  assign istream_rdy_o = (state_q == S_IDLE);
  assign ostream_val_o = bv_q;
  assign ostream_msg_o = buf_q;

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  // ASCII "A:B" in hex while calculating, spaces otherwise.
  function automatic logic [TW-1:0] trace();
    logic [TW-1:0]   s;
    logic [4*HD-1:0] ax;
    logic [4*HD-1:0] bx;
    s  = {(2*HD+1){8'h20}};
    ax = (4*HD)'(a_q);
    bx = (4*HD)'(b_q);
    if (state_q == S_CALC) begin
      for (int i = 0; i < int'(HD); i++) begin
        s[8*(int'(HD)+1+i) +: 8] = hex_ch(ax[4*i +: 4]);
        s[8*i +: 8]              = hex_ch(bx[4*i +: 4]);
      end
      s[8*HD +: 8] = 8'h3A;
    end
    return s;
  endfunction

endmodule

// File: tb/tb_gcd_unit_param.sv
// tb_gcd_unit_param: four gcd_unit_param configurations driven by
// directed and random streams against an arithmetic GCD reference.
module tb_gcd_unit_param;

  localparam int LIMIT = 15000;
  localparam int WID[4] = '{16, 16, 32, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  iv, ir, ov, orr;
  logic [31:0] im0;
  logic [15:0] om0;
  logic [31:0] im1;
  logic [15:0] om1;
  logic [63:0] im2;
  logic [31:0] om2;
  logic [15:0] im3;
  logic [7:0]  om3;

  gcd_unit_param #(.p_nbits(16), .p_algo(0)) u_e16 (
    .clk(clk), .rst(rst),
    .istream_val_i(iv[0]), .istream_rdy_o(ir[0]), .istream_msg_i(im0),
    .ostream_val_o(ov[0]), .ostream_rdy_i(orr[0]), .ostream_msg_o(om0));

  gcd_unit_param #(.p_nbits(16), .p_algo(1)) u_s16 (
    .clk(clk), .rst(rst),
    .istream_val_i(iv[1]), .istream_rdy_o(ir[1]), .istream_msg_i(im1),
    .ostream_val_o(ov[1]), .ostream_rdy_i(orr[1]), .ostream_msg_o(om1));

  gcd_unit_param #(.p_nbits(32), .p_algo(1)) u_s32 (
    .clk(clk), .rst(rst),
    .istream_val_i(iv[2]), .istream_rdy_o(ir[2]), .istream_msg_i(im2),
    .ostream_val_o(ov[2]), .ostream_rdy_i(orr[2]), .ostream_msg_o(om2));

  gcd_unit_param #(.p_nbits(8), .p_algo(1)) u_s8 (
    .clk(clk), .rst(rst),
    .istream_val_i(iv[3]), .istream_rdy_o(ir[3]), .istream_msg_i(im3),
    .ostream_val_o(ov[3]), .ostream_rdy_i(orr[3]), .ostream_msg_o(om3));

  int errs = 0;
  int checks = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] qe[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] msk(input int u);
    return (64'd1 << WID[u]) - 64'd1;
  endfunction

  function automatic logic [63:0] ref_gcd(input logic [63:0] a,
                                          input logic [63:0] b);
    longint unsigned x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic set_msg(input int u, input logic [63:0] a,
                         input logic [63:0] b);
    case (u)
      0: im0 = {a[15:0], b[15:0]};
      1: im1 = {a[15:0], b[15:0]};
      2: im2 = {a[31:0], b[31:0]};
      default: im3 = {a[7:0], b[7:0]};
    endcase
  endtask

  function automatic logic [63:0] get_om(input int u);
    case (u)
      0: return 64'(om0);
      1: return 64'(om1);
      2: return 64'(om2);
      default: return 64'(om3);
    endcase
  endfunction

  function automatic int pick(input int dly);
    return (dly < 0) ? int'($urandom_range(3, 0)) : dly;
  endfunction

  task automatic send_one(input int u, input logic [63:0] a,
                          input logic [63:0] b);
    int c;
    c = 0;
    @(negedge clk);
    set_msg(u, a, b);
    iv[u] = 1'b1;
    while (!ir[u] && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk($sformatf("u%0d accept", u), 64'(ir[u]), 64'd1);
    @(posedge clk);
    #1 iv[u] = 1'b0;
  endtask

  task automatic run_stream(input int u, input int dly);
    int ns, nr, sent, rcvd, sd, rd;
    ns = qa.size();
    nr = qe.size();
    sent = 0;
    rcvd = 0;
    sd = 0;
    rd = 0;
    fork
      begin
        int c;
        c = 0;
        while (sent < ns && c < LIMIT) begin
          @(negedge clk);
          c++;
          if (sd > 0) begin
            iv[u] = 1'b0;
            sd--;
          end else begin
            iv[u] = 1'b1;
            set_msg(u, qa[sent], qb[sent]);
            if (ir[u]) begin
              sent++;
              sd = pick(dly);
            end
          end
        end
        @(posedge clk);
        #1 iv[u] = 1'b0;
      end
      begin
        int c;
        c = 0;
        while (rcvd < nr && c < LIMIT) begin
          @(negedge clk);
          c++;
          if (rd > 0) begin
            orr[u] = 1'b0;
            rd--;
          end else begin
            orr[u] = 1'b1;
            if (ov[u]) begin
              chk($sformatf("u%0d res%0d", u, rcvd), get_om(u), qe[rcvd]);
              rcvd++;
              rd = pick(dly);
            end
          end
        end
        @(posedge clk);
        #1 orr[u] = 1'b1;
      end
    join
    chk($sformatf("u%0d sent", u), 64'(sent), 64'(ns));
    chk($sformatf("u%0d rcvd", u), 64'(rcvd), 64'(nr));
    repeat (3) @(negedge clk);
    chk($sformatf("u%0d no extra", u), 64'(ov[u]), 64'd0);
    qa.delete();
    qb.delete();
    qe.delete();
  endtask

  task automatic latency(input int u, input int exp);
    int found;
    found = -1;
    @(negedge clk);
    chk($sformatf("u%0d lat rdy", u), 64'(ir[u]), 64'd1);
    set_msg(u, 64'd15, 64'd5);
    iv[u] = 1'b1;
    @(posedge clk);
    #1 iv[u] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (ov[u]) begin
        found = k;
        break;
      end
    end
    chk($sformatf("u%0d latency", u), 64'(found), 64'(exp));
    chk($sformatf("u%0d lat msg", u), get_om(u), 64'd5);
    repeat (2) @(negedge clk);
  endtask

  task automatic load_directed();
    logic [63:0] da[9] = '{3, 0, 27, 21, 25, 19, 40, 250, 5};
    logic [63:0] db[9] = '{9, 0, 15, 49, 30, 27, 40, 190, 250};
    logic [63:0] de[9] = '{3, 0, 3, 7, 5, 1, 40, 10, 5};
    for (int i = 0; i < 9; i++) begin
      qa.push_back(da[i]);
      qb.push_back(db[i]);
      qe.push_back(de[i]);
    end
  endtask

  initial begin
    int useen;
    logic [63:0] ra, rb;
    int ru[3] = '{3, 1, 2};
    rst = 1'b1;
    iv  = '0;
    orr = '1;
    im0 = '0;
    im1 = '0;
    im2 = '0;
    im3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("u%0d rst rdy", u), 64'(ir[u]), 64'd1);
      chk($sformatf("u%0d rst val", u), 64'(ov[u]), 64'd0);
      chk($sformatf("u%0d rst msg", u), get_om(u), 64'd0);
    end

    latency(0, 5);
    latency(1, 4);

    for (int u = 0; u < 2; u++) begin
      load_directed();
      run_stream(u, 0);
      load_directed();
      run_stream(u, 3);
    end

    orr[0] = 1'b0;
    send_one(0, 64'd12, 64'd8);
    send_one(0, 64'd9, 64'd6);
    repeat (30) @(negedge clk);
    chk("bp val", 64'(ov[0]), 64'd1);
    chk("bp msg", get_om(0), 64'd4);
    chk("bp rdy", 64'(ir[0]), 64'd0);
    qe.push_back(64'd4);
    qe.push_back(64'd3);
    run_stream(0, 0);

    qa.push_back(64'hFFFF_FFFE); qb.push_back(64'h8000_0000);
    qe.push_back(64'd2);
    qa.push_back(64'hFFFF_FFFF); qb.push_back(64'd0);
    qe.push_back(64'hFFFF_FFFF);
    qa.push_back(64'd0);         qb.push_back(64'h10);
    qe.push_back(64'h10);
    run_stream(2, 0);

    send_one(0, 64'd1000, 64'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst val", 64'(ov[0]), 64'd0);
    chk("midrst rdy", 64'(ir[0]), 64'd1);
    useen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov[0]) useen++;
    end
    chk("midrst spurious", 64'(useen), 64'd0);
    qa.push_back(64'd18); qb.push_back(64'd12); qe.push_back(64'd6);
    run_stream(0, 0);

    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 100; i++) begin
        ra = {$urandom, $urandom} & msk(ru[j]);
        rb = {$urandom, $urandom} & msk(ru[j]);
        if ($urandom_range(9, 0) == 0) ra = '0;
        if ($urandom_range(9, 0) == 0) rb = '0;
        qa.push_back(ra);
        qb.push_back(rb);
        qe.push_back(ref_gcd(ra, rb));
      end
      run_stream(ru[j], -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
